// File: rtl/tv_sequencer.sv
// tv_sequencer: applies stored {inputs, expected} vectors to a combinational DUT and tallies mismatches
module tv_sequencer #(
    parameter int NUM_VECTORS = 8,
    parameter int IN_W        = 3,
    parameter int OUT_W       = 1,
    localparam int AW         = $clog2(NUM_VECTORS),
    localparam int CW         = $clog2(NUM_VECTORS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_en,
    input  logic [AW-1:0]         load_addr,
    input  logic [IN_W+OUT_W-1:0] load_data,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         err_count,
    output logic                  err_valid,
    output logic [AW-1:0]         first_err_idx
);
    localparam logic [1:0] IDLE = 2'd0, APPLY = 2'd1, SAMPLE = 2'd2, DONE = 2'd3;
    logic [IN_W+OUT_W-1:0] mem_q [NUM_VECTORS];
    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d, first_err_idx_q, first_err_idx_d;
    logic [IN_W-1:0] dut_in_q, dut_in_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic            done_q, done_d, err_valid_q, err_valid_d;
    logic            idle_ok, go, wr, last;
    logic [IN_W-1:0] vec_in;
    logic [OUT_W-1:0] vec_exp;
    assign idle_ok = state_q == IDLE || state_q == DONE;
    assign go      = start && idle_ok;
    assign wr      = reset && load_en && idle_ok;
    assign last    = idx_q == AW'(NUM_VECTORS - 1);
    assign vec_in  = mem_q[idx_q][IN_W+OUT_W-1:OUT_W];
    assign vec_exp = mem_q[idx_q][OUT_W-1:0];
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        dut_in_d        = dut_in_q;
        err_count_d     = err_count_q;
        err_valid_d     = err_valid_q;
        first_err_idx_d = first_err_idx_q;
        done_d          = done_q;
        if (go) begin
            state_d         = APPLY;
            idx_d           = '0;
            err_count_d     = '0;
            err_valid_d     = 1'b0;
            first_err_idx_d = '0;
            done_d          = 1'b0;
        end else begin
            case (state_q)
                APPLY: begin
                    dut_in_d = vec_in;
                    state_d  = SAMPLE;
                end
                SAMPLE: begin
                    if (dut_out != vec_exp) begin
                        err_count_d     = err_count_q + CW'(1);
                        err_valid_d     = 1'b1;
                        first_err_idx_d = err_valid_q ? first_err_idx_q : idx_q;
                    end
                    state_d = last ? DONE : APPLY;
                    idx_d   = last ? idx_q : idx_q + AW'(1);
                end
                DONE:    done_d = 1'b1;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            dut_in_q        <= '0;
            err_count_q     <= '0;
            err_valid_q     <= 1'b0;
            first_err_idx_q <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            dut_in_q        <= dut_in_d;
            err_count_q     <= err_count_d;
            err_valid_q     <= err_valid_d;
            first_err_idx_q <= first_err_idx_d;
            done_q          <= done_d;
        end
    end
    // vector memory survives reset so a sweep can be rerun without reloading
    always_ff @(posedge clk) begin
        if (wr) mem_q[load_addr] <= load_data;
    end
    assign dut_in        = dut_in_q;
    assign busy          = state_q == APPLY || state_q == SAMPLE;
    assign done          = done_q;
    assign err_count     = err_count_q;
    assign err_valid     = err_valid_q;
    assign first_err_idx = first_err_idx_q;
endmodule
